// File: rtl/uart_param.sv
// Parametrised full-duplex UART: TX sends switch_i on a send_i rising edge,
// RX oversamples rx_i and reports each frame on led_o with error flags.
module uart_param #(
  parameter int unsigned CLK_HZ     = 40000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              tx_o,
  input  logic [DATA_W-1:0] switch_i,
  input  logic              send_i,
  output logic [DATA_W-1:0] led_o,
  output logic              tx_busy_o,
  output logic              rx_valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o
);

  localparam int unsigned DIV      = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned BIT_CYC  = DIV * OVERSAMPLE;
  localparam int unsigned TX_CNT_W = $clog2(STOP_BITS * BIT_CYC + 1);
  localparam int unsigned DIV_W    = $clog2(DIV + 1);
  localparam int unsigned TICK_W   = $clog2(OVERSAMPLE + 1);
  localparam int unsigned IDX_W    = $clog2(DATA_W + 1);
  localparam logic        PAR_EN   = (PARITY != 0);
  localparam logic        PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

  // ---------------- synchronisers and edge detectors ----------------
  logic send_s1_q, send_s1_d, send_s2_q, send_s2_d, send_prev_q, send_prev_d;
  logic send_rise_q, send_rise_d;
  logic rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic rx_fall_c;

  // Synchroniser flops reset high so no spurious edge appears after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      send_s1_q   <= 1'b1;
      send_s2_q   <= 1'b1;
      send_prev_q <= 1'b1;
      send_rise_q <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      send_s1_q   <= send_s1_d;
      send_s2_q   <= send_s2_d;
      send_prev_q <= send_prev_d;
      send_rise_q <= send_rise_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
    end
  end

  // Two-flop synchronisers; send edge is registered, rx falling edge is combinational
  always_comb begin
    send_s1_d   = send_i;
    send_s2_d   = send_s1_q;
    send_prev_d = send_s2_q;
    send_rise_d = send_s2_q & ~send_prev_q;
    rx_s1_d     = rx_i;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_fall_c   = rx_prev_q & ~rx_s2_q;
  end

  // ---------------- transmitter ----------------
  tx_state_e           tx_state_q, tx_state_d;
  logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0]    tx_idx_q, tx_idx_d;
  logic                tx_par_q, tx_par_d;
  logic                tx_q, tx_d;
  logic                tx_busy_q, tx_busy_d;
  logic                tx_bit_end_c, tx_stop_end_c;

  // TX state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // TX next state: line level is registered and changes on state entry
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q + TX_CNT_W'(1);
    tx_shift_d    = tx_shift_q;
    tx_idx_d      = tx_idx_q;
    tx_par_d      = tx_par_q;
    tx_d          = tx_q;
    tx_busy_d     = tx_busy_q;
    tx_bit_end_c  = (tx_cnt_q == TX_CNT_W'(BIT_CYC - 1));
    tx_stop_end_c = (tx_cnt_q == TX_CNT_W'(STOP_BITS * BIT_CYC - 1));
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (send_rise_q) begin
          tx_shift_d = switch_i;
          tx_par_d   = (^switch_i) ^ PAR_ODD;
          tx_busy_d  = 1'b1;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end_c) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end_c) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_W'(DATA_W - 1)) begin
            if (PAR_EN) begin
              tx_d       = tx_par_q;
              tx_state_d = TX_PAR;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_idx_d   = tx_idx_q + IDX_W'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TX_PAR: begin
        if (tx_bit_end_c) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_stop_end_c) begin
          tx_cnt_d   = '0;
          tx_busy_d  = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
        tx_busy_d  = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_e         rx_state_q, rx_state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_par_q, rx_par_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic              rx_valid_q, rx_valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              tick_c, half_c, full_c;

  // RX state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      div_q      <= '0;
      tick_q     <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      led_q      <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      led_q      <= led_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // RX next state: tick divider runs only while a frame is in progress
  always_comb begin
    rx_state_d = rx_state_q;
    div_d      = div_q;
    tick_d     = tick_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    led_d      = led_q;
    rx_valid_d = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    tick_c     = (div_q == DIV_W'(DIV - 1));
    half_c     = tick_c && (tick_q == TICK_W'(OVERSAMPLE / 2 - 1));
    full_c     = tick_c && (tick_q == TICK_W'(OVERSAMPLE - 1));
    if (rx_state_q != RX_IDLE) begin
      div_d = tick_c ? '0 : div_q + DIV_W'(1);
      if (tick_c) tick_d = tick_q + TICK_W'(1);
    end
    case (rx_state_q)
      RX_IDLE: begin
        div_d  = '0;
        tick_d = '0;
        if (rx_fall_c) rx_state_d = RX_START;
      end
      RX_START: begin
        if (half_c) begin
          tick_d     = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (full_c) begin
          tick_d     = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
          if (rx_idx_q == IDX_W'(DATA_W - 1)) begin
            rx_state_d = PAR_EN ? RX_PAR : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end
      end
      RX_PAR: begin
        if (full_c) begin
          tick_d     = '0;
          rx_par_d   = rx_s2_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (full_c) begin
          tick_d     = '0;
          led_d      = rx_shift_q;
          ferr_d     = ~rx_s2_q;
          perr_d     = PAR_EN ? (rx_par_q ^ (^rx_shift_q) ^ PAR_ODD) : 1'b0;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign tx_o         = tx_q;
  assign tx_busy_o    = tx_busy_q;
  assign led_o        = led_q;
  assign rx_valid_o   = rx_valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_param.sv
// Directed loopback / injected-frame bench for uart_param (8N1 and 7E2 instances).
module tb_uart_param;

  localparam int unsigned BIT_CYC = 352;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       send0 = 1'b0, send1 = 1'b0;
  logic [7:0] sw0 = '0;
  logic [6:0] sw1 = '0;
  logic       brx = 1'b1, sel0 = 1'b0, sel1 = 1'b0;
  logic       rx0, rx1, tx0, tx1;
  logic [7:0] led0;
  logic [6:0] led1;
  logic       busy0, busy1, vld0, vld1, perr0, perr1, ferr0, ferr1;

  assign rx0 = sel0 ? brx : tx0;
  assign rx1 = sel1 ? brx : tx1;

  uart_param dut0 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx0), .tx_o(tx0), .switch_i(sw0), .send_i(send0),
    .led_o(led0), .tx_busy_o(busy0), .rx_valid_o(vld0), .parity_err_o(perr0), .frame_err_o(ferr0)
  );

  uart_param #(.DATA_W(7), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx1), .tx_o(tx1), .switch_i(sw1), .send_i(send1),
    .led_o(led1), .tx_busy_o(busy1), .rx_valid_o(vld1), .parity_err_o(perr1), .frame_err_o(ferr1)
  );

  // Frame, busy-length and rx_valid bookkeeping
  int   cyc = 0, frames0 = 0, frames1 = 0, vcnt0 = 0, vcnt1 = 0;
  int   rise0 = 0, rise1 = 0, len0 = 0, len1 = 0;
  logic bprev0 = 1'b0, bprev1 = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    bprev0 <= busy0;
    bprev1 <= busy1;
    if (busy0 && !bprev0) begin frames0 <= frames0 + 1; rise0 <= cyc; end
    if (!busy0 && bprev0) len0 <= cyc - rise0;
    if (busy1 && !bprev1) begin frames1 <= frames1 + 1; rise1 <= cyc; end
    if (!busy1 && bprev1) len1 <= cyc - rise1;
    if (vld0) vcnt0 <= vcnt0 + 1;
    if (vld1) vcnt1 <= vcnt1 + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input bit which);
    int n;
    n = 0;
    while ((which ? busy1 : busy0) !== 1'b0 && n < 6000) begin
      @(posedge clk); #1; n++;
    end
    check_eq(which ? "busy1_done" : "busy0_done", 32'(which ? busy1 : busy0), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic send_word(input bit which, input logic [7:0] d);
    @(negedge clk);
    if (which) begin sw1 = d[6:0]; send1 = 1'b1; end
    else       begin sw0 = d;      send0 = 1'b1; end
    repeat (5) @(negedge clk);
    send0 = 1'b0;
    send1 = 1'b0;
    wait_idle(which);
  endtask

  task automatic drive_frame(input logic [7:0] d, input int nbits, input bit par_en,
                             input logic par_bit, input int nstop, input logic stop_val);
    @(negedge clk);
    brx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      brx = d[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    if (par_en) begin
      brx = par_bit;
      repeat (BIT_CYC) @(negedge clk);
    end
    brx = stop_val;
    repeat (BIT_CYC * nstop) @(negedge clk);
    brx = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, f, v;

    // Reset values
    repeat (5) @(negedge clk);
    check_eq("rst_tx", tx0, 1);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_led", led0, 0);
    check_eq("rst_flags", {perr0, ferr0, vld0}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 8N1 loopback 0x43 with latency measurement
    v = vcnt0;
    sw0 = 8'h43;
    @(negedge clk); send0 = 1'b1;
    @(posedge clk);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (tx0 !== 1'b0 && n < 10);
    check_eq("tx_latency", n, 3);
    check_eq("busy_at_start", busy0, 1);
    @(negedge clk); send0 = 1'b0;
    wait_idle(0);
    check_eq("len_8n1", len0, 3520);
    check_eq("led_43", led0, 8'h43);
    check_eq("valid_43", vcnt0 - v, 1);
    check_eq("flags_43", {perr0, ferr0}, 0);

    // send_i held high for 500 us -> one frame only
    f = frames0; v = vcnt0;
    sw0 = 8'h32;
    @(negedge clk); send0 = 1'b1;
    repeat (20000) @(negedge clk);
    check_eq("held_frames", frames0 - f, 1);
    check_eq("held_valid", vcnt0 - v, 1);
    check_eq("led_32", led0, 8'h32);
    send0 = 1'b0;
    repeat (10) @(negedge clk);

    // Second edge and switch change mid-frame are ignored
    f = frames0;
    sw0 = 8'h5A;
    @(negedge clk); send0 = 1'b1;
    repeat (5) @(negedge clk); send0 = 1'b0;
    repeat (500) @(negedge clk);
    sw0 = 8'hFF; send0 = 1'b1;
    repeat (5) @(negedge clk); send0 = 1'b0;
    wait_idle(0);
    repeat (400) @(negedge clk);
    check_eq("no_queue_frames", frames0 - f, 1);
    check_eq("led_5a", led0, 8'h5A);

    // 7E2 loopback 0x22: parity bit 0, 11 bit times
    v = vcnt1;
    sw1 = 7'h22;
    @(negedge clk); send1 = 1'b1;
    n = 0;
    while (tx1 !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("tx1_started", tx1, 0);
    repeat (8 * BIT_CYC + BIT_CYC / 2) @(posedge clk);
    #1;
    check_eq("par_bit_22", tx1, 0);
    send1 = 1'b0;
    wait_idle(1);
    check_eq("len_7e2", len1, 11 * BIT_CYC);
    check_eq("led1_22", led1, 7'h22);
    check_eq("perr1_good", perr1, 0);
    check_eq("ferr1_good", ferr1, 0);
    check_eq("valid1_good", vcnt1 - v, 1);

    // 7E2 injected frame with flipped parity bit
    v = vcnt1;
    sel1 = 1'b1;
    drive_frame(8'h22, 7, 1'b1, 1'b1, 2, 1'b1);
    check_eq("perr1_bad", perr1, 1);
    check_eq("led1_bad_par", led1, 7'h22);
    check_eq("valid1_bad_par", vcnt1 - v, 1);
    sel1 = 1'b0;

    // 8N1 injected 0xA5 with low stop bit
    v = vcnt0;
    sel0 = 1'b1;
    drive_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0);
    check_eq("ferr_a5", ferr0, 1);
    check_eq("led_a5", led0, 8'hA5);
    check_eq("perr0_tied", perr0, 0);
    check_eq("valid_a5", vcnt0 - v, 1);
    sel0 = 1'b0;
    repeat (10) @(negedge clk);

    // Next good frame clears the frame error
    send_word(0, 8'h7E);
    check_eq("ferr_cleared", ferr0, 0);
    check_eq("led_7e", led0, 8'h7E);

    // 100-cycle glitch on idle line is a false start
    v = vcnt0;
    sel0 = 1'b1;
    @(negedge clk); brx = 1'b0;
    repeat (100) @(negedge clk);
    brx = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("glitch_valid", vcnt0 - v, 0);
    check_eq("glitch_led", led0, 8'h7E);
    check_eq("glitch_flags", {perr0, ferr0}, 0);
    sel0 = 1'b0;

    // Reset mid-transmit, then a clean frame
    sw0 = 8'h99;
    @(negedge clk); send0 = 1'b1;
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_tx", tx0, 1);
    check_eq("midrst_busy", busy0, 0);
    check_eq("midrst_led", led0, 0);
    send0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    v = vcnt0;
    send_word(0, 8'h3C);
    check_eq("post_rst_led", led0, 8'h3C);
    check_eq("post_rst_len", len0, 3520);
    check_eq("post_rst_valid", vcnt0 - v, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_param.md
# uart_param

Parametrised successor to the lab-0 UART. It is a full-duplex serial transceiver with configurable clock and baud rates, data width, parity and stop bits. It loads the byte on `switch_i` and transmits it on a rising edge of `send_i`, and shows each received word on `led_o`. It adds status and error outputs, so the lab top level and the loopback bench (`tx_o` wired to `rx_i`) can check frames cycle by cycle.

## Interface
Parameters:
- `CLK_HZ`, 40000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: receiver ticks per bit. Must be even and at least 8.
- `DATA_W`, 8: data bits per frame, from 5 to 9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits sent, 1 or 2. The receiver checks only the first stop bit.

Derived constants:
- `DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)`, i.e. rounded to nearest.
- `BIT_CYC = DIV*OVERSAMPLE`.
- With the defaults, `DIV` = 22 and `BIT_CYC` = 352.

Ports:
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `rx_i` in 1: serial input. Asynchronous; idles high.
- `tx_o` out 1: serial output. Idles high.
- `switch_i` in DATA_W: word to transmit, captured at send start.
- `send_i` in 1: transmit request. Asynchronous level; only its rising edge acts.
- `led_o` out DATA_W: last received data word.
- `tx_busy_o` out 1: high while a frame is being transmitted.
- `rx_valid_o` out 1: one-cycle pulse when a frame completes.
- `parity_err_o` out 1: last frame had bad parity. Tied 0 when `PARITY` = 0.
- `frame_err_o` out 1: last frame's stop bit was sampled low.

## Operation
- Reset values:
  - `tx_o` = 1. `led_o`, `tx_busy_o`, `rx_valid_o`, `parity_err_o`, `frame_err_o` = 0.
  - All FSMs go to IDLE; all synchroniser flops are set to 1.
- `send_i` and `rx_i` each pass through a 2-flop synchroniser. An edge detector follows each synchroniser.
- TX FSM: IDLE → START → DATA → PARITY (skipped when `PARITY` = 0) → STOP → IDLE.
  - In IDLE, a synchronised rising edge of `send_i` latches `switch_i`, sets `tx_busy_o` and enters START.
  - Each state holds its line level for exactly `BIT_CYC` cycles, timed by a counter cleared on entry.
  - START drives 0. DATA sends the word LSB first, `DATA_W` bits.
  - PARITY drives the XOR of the data bits, inverted for odd parity.
  - STOP drives 1 for `STOP_BITS`×`BIT_CYC` cycles.
  - Rising edges of `send_i` outside IDLE are ignored, not queued. Holding `send_i` high sends exactly one frame.
  - Changing `switch_i` mid-frame has no effect on the frame in flight.
- RX FSM: IDLE → START → DATA → PARITY (when enabled) → STOP → IDLE.
  - A falling edge of synchronised `rx_i` in IDLE restarts the tick divider and enters START.
  - The divider produces one tick every `DIV` cycles.
  - START: at `OVERSAMPLE/2` ticks the line is sampled. If it is high, this is a false start: return to IDLE with no flags changed. If it is low, go on.
  - After that, every subsequent sample is taken `OVERSAMPLE` ticks after the previous one, i.e. mid-bit. Data is shifted in LSB first.
  - STOP sample:
    - Update `led_o` with the received word.
    - Set `frame_err_o` to the inverse of the stop sample.
    - Set `parity_err_o` to the parity mismatch.
    - Pulse `rx_valid_o` for 1 cycle.
    - Return to IDLE immediately, so back-to-back frames are received.
  - A frame error still updates `led_o`. Both error flags hold their value until the next completed frame.
  - When `DATA_W` < 8 the word is right-aligned; there are no unused upper `led_o` bits, because `led_o` is `DATA_W` wide.
- TX and RX are independent. In loopback, a frame is received while it is being sent.
- `rst_i` asserted mid-frame: `tx_o` goes to 1 and all outputs and FSMs take their reset values asynchronously. The partial frame is discarded.

## Timing
- TX latency: if `send_i` is first sampled high at clock edge N, the edge detector fires at N+2. `tx_o` and `tx_busy_o` go to 0/1 respectively at edge N+3.
- Frame length is (1 + `DATA_W` + (`PARITY` ≠ 0) + `STOP_BITS`)×`BIT_CYC` cycles. For 8N1 at the defaults this is 3520 cycles (88 µs).
- `tx_busy_o` falls on the same edge at which the STOP period ends. A new send edge is accepted from the following cycle.
- RX sampling:
  - Mid-bit is reached 2 cycles (synchroniser) + `DIV`×`OVERSAMPLE`/2 cycles after the start-bit falling edge, then every `BIT_CYC` cycles.
  - `rx_valid_o` and `led_o` update on the same edge.
- Tolerated baud error is at least ±2% at `OVERSAMPLE` = 16.

## Test plan
- Defaults, loopback, `switch_i` = 0x43, `send_i` pulse:
  - `tx_o` falls 3 cycles after the sampled edge.
  - `tx_busy_o` is high for 3520 cycles.
  - `rx_valid_o` pulses once and `led_o` = 0x43.
  - Both error flags = 0.
- `send_i` held high for 500 µs with `switch_i` = 0x32 → exactly one frame is sent and `led_o` = 0x32. A second rising edge during busy → no extra frame.
- `PARITY` = 2, `DATA_W` = 7, `STOP_BITS` = 2, loopback 0x22:
  - Frame length is 11×352 cycles and the parity bit is 0.
  - `led_o` = 0x22, `parity_err_o` = 0.
  - Bench flips the parity bit on the line → `parity_err_o` = 1 and `rx_valid_o` still pulses.
- Bench drives the stop bit low on a 0xA5 frame → `frame_err_o` = 1 and `led_o` = 0xA5. The next good frame clears `frame_err_o`.
- A 100-cycle low glitch on idle `rx_i` → false start. There is no `rx_valid_o`, and `led_o` and the flags are unchanged.
- Assert `rst_i` mid-transmit → `tx_o` = 1 and `tx_busy_o` = 0 immediately. After release, a new send completes normally.
